// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache with its line refill controller.
// Lookup is combinational in IDLE; a miss walks REQ -> FILL -> DONE and then
// replays the lookup. Hit/miss performance counters are built only when the
// ICACHE_PERF_EN macro is defined; otherwise both counter ports read zero.
module icache_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic [XLEN-1:0] cpu_addr,
    output logic            cpu_ready,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_stall,
    input  logic            flush,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);

    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = XLEN - IDX_W - OFF_W;
    localparam int unsigned LINE_W = XLEN - OFF_W;

    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [XLEN-1:0]      data_q [NUM_LINES][LINE_WORDS];
    logic [LINE_W-1:0]    miss_line_q;
    logic [WORD_W-1:0]    beat_cnt_q;
    logic                 flush_pend_q;

    logic [WORD_W-1:0] cpu_word;
    logic [IDX_W-1:0]  cpu_index;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  miss_index;
    logic [TAG_W-1:0]  miss_tag;

    logic lookup;
    logic hit;
    logic miss_start;
    logic req_fire;
    logic beat_fire;
    logic last_beat;
    logic drop_line;

    // Byte-offset bits never select anything in a word-wide fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_word   = cpu_addr[OFF_W-1:2];
    assign cpu_index  = cpu_addr[OFF_W+IDX_W-1:OFF_W];
    assign cpu_tag    = cpu_addr[XLEN-1:OFF_W+IDX_W];
    assign miss_index = miss_line_q[IDX_W-1:0];
    assign miss_tag   = miss_line_q[LINE_W-1:IDX_W];

    // A flush in IDLE suppresses both the hit and the refill for this cycle.
    assign lookup     = (state_q == IDLE) && cpu_req && !flush;
    assign hit        = lookup && valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
    assign miss_start = lookup && !hit;
    assign req_fire   = (state_q == REQ) && mem_req_ready;
    assign beat_fire  = (state_q == FILL) && mem_rsp_valid;
    assign last_beat  = beat_fire && (beat_cnt_q == LAST_BEAT);
    // A flush seen at any point of the refill (including DONE itself) drops the line.
    assign drop_line  = flush_pend_q || flush;

    assign cpu_ready     = hit;
    assign cpu_rdata     = hit ? data_q[cpu_index][cpu_word] : '0;
    assign cpu_stall     = cpu_req && !hit;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = (state_q == REQ) ? {miss_line_q, {OFF_W{1'b0}}} : '0;

    // Refill sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (miss_start) state_d = REQ;
            REQ:  if (req_fire)   state_d = FILL;
            FILL: if (last_beat)  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state, latched miss line, beat counter and pending flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            miss_line_q  <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_line_q <= cpu_addr[XLEN-1:OFF_W];
            end
            if (req_fire) begin
                beat_cnt_q <= '0;
            end else if (beat_fire) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (state_q == DONE) begin
                flush_pend_q <= 1'b0;
            end else if ((state_q != IDLE) && flush) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    // Valid bits: cleared on miss entry so a partial line never hits, set in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (state_q == IDLE) begin
            if (flush) begin
                valid_q <= '0;
            end else if (miss_start) begin
                valid_q[cpu_index] <= 1'b0;
            end
        end else if (state_q == DONE) begin
            if (drop_line) begin
                valid_q <= '0;
            end else begin
                valid_q[miss_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (beat_fire) begin
                data_q[miss_index][beat_cnt_q] <= mem_rsp_data;
            end
            if ((state_q == DONE) && !drop_line) begin
                tag_q[miss_index] <= miss_tag;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cpu_req && cpu_ready) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed scenarios plus randomized fetch traffic, checked
// against a line-level cache model (valid/tag/words per index).
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of cache contents and counters.
    bit          m_valid [32];
    logic [22:0] m_tag   [32];
    logic [31:0] m_data  [32][4];
    int          m_hits;
    int          m_misses;

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .cpu_stall     (cpu_stall),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] idx_of(input logic [31:0] a);
        return a[8:4];
    endfunction

    function automatic logic [22:0] tag_of(input logic [31:0] a);
        return a[31:9];
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_PERF_EN
        check_eq({tag, "_hit_count"}, hit_count, 32'(m_hits));
        check_eq({tag, "_miss_count"}, miss_count, 32'(m_misses));
`else
        check_eq({tag, "_hit_count"}, hit_count, 32'd0);
        check_eq({tag, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        cpu_req       = 1'b0;
        cpu_addr      = '0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        @(negedge clk);
        check_eq("rst_mem_req_valid", mem_req_valid, 1'b0);
        check_eq("rst_mem_req_addr", mem_req_addr, 32'd0);
        check_eq("rst_cpu_ready", cpu_ready, 1'b0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_eq("rst_cpu_stall", cpu_stall, 1'b0);
        check_counters("rst");
    endtask

    // One fetch. On a model miss the bench plays memory: req_wait cycles of
    // back-pressure, gap idle cycles before every beat, optional flush with
    // beat flush_at, optional reset right after beat rst_at is accepted.
    task automatic fetch(input logic [31:0] addr, input int req_wait, input int gap,
                         input int flush_at, input int rst_at, input logic [31:0] base);
        logic [31:0] line;
        int          stalls;
        int          exp_stalls;
        bit          flushed;
        line    = {addr[31:4], 4'h0};
        stalls  = 0;
        flushed = 1'b0;
        @(posedge clk);
        #1 cpu_req = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        if (model_hit(addr)) begin
            check_eq("hit_ready", cpu_ready, 1'b1);
            check_eq("hit_rdata", cpu_rdata, m_data[idx_of(addr)][addr[3:2]]);
            check_eq("hit_stall", cpu_stall, 1'b0);
            m_hits++;
        end else begin
            check_eq("miss_ready", cpu_ready, 1'b0);
            check_eq("miss_req_early", mem_req_valid, 1'b0);
            stalls += int'(cpu_stall);
            m_misses++;
            m_valid[idx_of(addr)] = 1'b0;
            // Request phase; junk response beats here must be ignored.
            for (int w = 0; w <= req_wait; w++) begin
                @(posedge clk);
                #1 mem_req_ready = (w == req_wait);
                mem_rsp_valid = (w != req_wait) ? 1'($urandom_range(1, 0)) : 1'b0;
                mem_rsp_data  = $urandom;
                @(negedge clk);
                check_eq("req_valid", mem_req_valid, 1'b1);
                check_eq("req_addr", mem_req_addr, line);
                check_eq("req_ready_low", cpu_ready, 1'b0);
                stalls += int'(cpu_stall);
            end
            @(posedge clk);
            #1 mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            for (int b = 0; b < 4; b++) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check_eq("fill_gap_ready", cpu_ready, 1'b0);
                    stalls += int'(cpu_stall);
                    @(posedge clk);
                    #1;
                end
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = base + 32'(b);
                flush         = (b == flush_at);
                if (b == flush_at) flushed = 1'b1;
                @(negedge clk);
                check_eq("fill_ready", cpu_ready, 1'b0);
                check_eq("fill_req_valid", mem_req_valid, 1'b0);
                stalls += int'(cpu_stall);
                @(posedge clk);
                #1 mem_rsp_valid = 1'b0;
                flush = 1'b0;
                if (b == rst_at) begin
                    rst     = 1'b1;
                    cpu_req = 1'b0;
                    @(posedge clk);
                    #1 rst = 1'b0;
                    model_clear();
                    m_hits   = 0;
                    m_misses = 0;
                    @(negedge clk);
                    check_eq("midrst_req_valid", mem_req_valid, 1'b0);
                    check_eq("midrst_req_addr", mem_req_addr, 32'd0);
                    check_eq("midrst_ready", cpu_ready, 1'b0);
                    check_counters("midrst");
                    return;
                end
            end
            // Now in DONE.
            if (flushed) cpu_req = 1'b0;
            @(negedge clk);
            check_eq("done_ready", cpu_ready, 1'b0);
            stalls += int'(cpu_stall);
            @(posedge clk);
            #1;
            @(negedge clk);
            if (flushed) begin
                model_clear();
                check_eq("flushed_no_ready", cpu_ready, 1'b0);
                check_eq("flushed_no_req", mem_req_valid, 1'b0);
            end else begin
                m_valid[idx_of(addr)] = 1'b1;
                m_tag[idx_of(addr)]   = tag_of(addr);
                for (int b = 0; b < 4; b++) m_data[idx_of(addr)][b] = base + 32'(b);
                exp_stalls = 7 + req_wait + 4 * gap;
                check_eq("miss_stall_cycles", 32'(stalls), 32'(exp_stalls));
                check_eq("replay_ready", cpu_ready, 1'b1);
                check_eq("replay_rdata", cpu_rdata, base + 32'(addr[3:2]));
                m_hits++;
            end
        end
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(negedge clk);
        check_counters("fetch");
    endtask

    task automatic flush_idle(input logic [31:0] addr);
        @(posedge clk);
        #1 flush = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(negedge clk);
        check_eq("fidle_ready", cpu_ready, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        cpu_req = 1'b0;
        model_clear();
        @(negedge clk);
        check_eq("fidle_no_req", mem_req_valid, 1'b0);
        check_counters("fidle");
    endtask

    initial begin
        do_reset();

        // Cold miss, best-case memory, then a zero-latency hit on word 3.
        fetch(32'h100, 0, 0, -1, -1, 32'hA0);
        fetch(32'h10C, 0, 0, -1, -1, 32'h0);
        // Conflict on index 16.
        fetch(32'h300, 0, 0, -1, -1, 32'hB0);
        fetch(32'h100, 0, 0, -1, -1, 32'hC0);
        // Back-pressure and gapped beats; then read every word back.
        fetch(32'h2040, 5, 3, -1, -1, 32'hD000);
        for (int w = 0; w < 4; w++) fetch(32'h2040 + 32'(4 * w), 0, 0, -1, -1, 32'h0);
        // Flush during FILL: line stays invalid and misses next time.
        fetch(32'h500, 1, 1, 1, -1, 32'hE0);
        fetch(32'h500, 0, 0, -1, -1, 32'hE8);
        // Flush in IDLE drops every line.
        fetch(32'h104, 0, 0, -1, -1, 32'h0);
        flush_idle(32'h104);
        fetch(32'h104, 0, 0, -1, -1, 32'hF0);
        fetch(32'h2044, 0, 0, -1, -1, 32'hF8);
        // Reset after two beats abandons the refill.
        fetch(32'h700, 0, 1, -1, 1, 32'h70);
        fetch(32'h700, 0, 0, -1, -1, 32'h78);
        fetch(32'h104, 0, 0, -1, -1, 32'h80);
        // Counters: fresh reset, one miss (with replay hit) and two hits.
        do_reset();
        fetch(32'h900, 0, 0, -1, -1, 32'h90);
        fetch(32'h904, 0, 0, -1, -1, 32'h0);
        fetch(32'h908, 0, 0, -1, -1, 32'h0);

        // Random traffic over a small address pool to force conflicts.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int          fa;
            int          ra;
            a  = (32'($urandom_range(3, 0)) << 9) | (32'($urandom_range(3, 0)) << 4)
               | (32'($urandom_range(3, 0)) << 2);
            fa = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            ra = ($urandom_range(24, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            if ($urandom_range(15, 0) == 0) begin
                flush_idle(a);
            end else begin
                fetch(a, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), fa, ra,
                      $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
